// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one combinational OPW x OPW multiplier between two
// requesters; operands are registered, held for SETTLE cycles, then the product is returned.
module mul_share_arbiter #(
  parameter int OPW    = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [OPW-1:0]   req0_a,
  input  logic [OPW-1:0]   req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [OPW-1:0]   req1_a,
  input  logic [OPW-1:0]   req1_b,
  output logic             req1_ready,
  output logic [OPW-1:0]   mul_a,
  output logic [OPW-1:0]   mul_b,
  input  logic [2*OPW-1:0] mul_product,
  output logic             rsp_valid,
  output logic [2*OPW-1:0] rsp_product,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [15:0]      op_count
);

  // state | meaning
  // IDLE  | arbitrating; the winner (if any) is accepted this cycle
  // ISSUE | operands held on the multiplier while the settle counter runs down
  // RESP  | product held on the response port until rsp_ready
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  if (SETTLE < 1 || SETTLE > 15) begin : g_settle_bad
    $error("mul_share_arbiter: SETTLE must be within 1..15");
  end

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [OPW-1:0]   mul_a_q, mul_a_d;
  logic [OPW-1:0]   mul_b_q, mul_b_d;
  logic [2*OPW-1:0] rsp_product_q, rsp_product_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      op_count_q, op_count_d;

  logic idle;
  logic grant0;
  logic grant1;

  // Under contention the requester that did not win most recently gets the grant.
  assign idle   = (state_q == ST_IDLE);
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);

  assign req0_ready  = idle & grant0;
  assign req1_ready  = idle & grant1;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign rsp_id      = rsp_id_q;
  assign busy        = ~idle;
  assign op_count    = op_count_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rsp_product_d = rsp_product_q;
    rsp_id_d      = rsp_id_q;
    rsp_valid_d   = rsp_valid_q;
    op_count_d    = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready | req1_ready) begin
          mul_a_d  = req1_ready ? req1_a : req0_a;
          mul_b_d  = req1_ready ? req1_b : req0_b;
          rsp_id_d = req1_ready;
          last_d   = req1_ready;
          cnt_d    = SETTLE_M1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == 4'd0) begin
          rsp_product_d = mul_product;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      last_q        <= 1'b1;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rsp_product_q <= '0;
      rsp_id_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      op_count_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rsp_product_q <= rsp_product_d;
      rsp_id_q      <= rsp_id_d;
      rsp_valid_q   <= rsp_valid_d;
      op_count_q    <= op_count_d;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: one instance with SETTLE=1 and one with SETTLE=4, each
// against a transaction-level model of arbitration order, latency, product and op count.
module tb_mul_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0]       req0_valid, req1_valid, rsp_ready;
  logic [1:0][3:0]  req0_a, req0_b, req1_a, req1_b;
  wire  [1:0]       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  wire  [1:0][3:0]  mul_a, mul_b;
  wire  [1:0][7:0]  mul_product, rsp_product;
  wire  [1:0][15:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int settle_m [2] = '{1, 4};
  logic last_m [2];
  int   count_m[2];

  // shared multipliers modelled as plain combinational products
  assign mul_product[0] = {4'b0, mul_a[0]} * {4'b0, mul_b[0]};
  assign mul_product[1] = {4'b0, mul_a[1]} * {4'b0, mul_b[1]};

  mul_share_arbiter #(.OPW(4), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req0_valid(req0_valid[0]), .req0_a(req0_a[0]), .req0_b(req0_b[0]), .req0_ready(req0_ready[0]),
    .req1_valid(req1_valid[0]), .req1_a(req1_a[0]), .req1_b(req1_b[0]), .req1_ready(req1_ready[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_product(mul_product[0]),
    .rsp_valid(rsp_valid[0]), .rsp_product(rsp_product[0]), .rsp_id(rsp_id[0]),
    .rsp_ready(rsp_ready[0]), .busy(busy[0]), .op_count(op_count[0])
  );

  mul_share_arbiter #(.OPW(4), .SETTLE(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req0_valid(req0_valid[1]), .req0_a(req0_a[1]), .req0_b(req0_b[1]), .req0_ready(req0_ready[1]),
    .req1_valid(req1_valid[1]), .req1_a(req1_a[1]), .req1_b(req1_b[1]), .req1_ready(req1_ready[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_product(mul_product[1]),
    .rsp_valid(rsp_valid[1]), .rsp_product(rsp_product[1]), .rsp_id(rsp_id[1]),
    .rsp_ready(rsp_ready[1]), .busy(busy[1]), .op_count(op_count[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered and left just after a falling edge. One full operation on instance d:
  // request, settle window, response with bp cycles of backpressure, completion.
  task automatic do_op(input int d, input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1, input int bp);
    logic       w;
    logic [3:0] ea, eb;
    logic [7:0] ep;
    if (v0 && v1) w = ~last_m[d];
    else          w = v1;
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    ep = 8'(int'(ea) * int'(eb));
    req0_valid[d] = v0; req0_a[d] = a0; req0_b[d] = b0;
    req1_valid[d] = v1; req1_a[d] = a1; req1_b[d] = b1;
    #1;
    check("grant_ready0", 32'(req0_ready[d]), 32'(!w));
    check("grant_ready1", 32'(req1_ready[d]), 32'(w));
    @(posedge clk);
    #1;
    if (w) req1_valid[d] = 1'b0;
    else   req0_valid[d] = 1'b0;
    last_m[d] = w;
    for (int k = 1; k <= settle_m[d]; k++) begin
      @(negedge clk);
      check("issue_busy", 32'(busy[d]), 32'd1);
      check("issue_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("issue_mul_a", 32'(mul_a[d]), 32'(ea));
      check("issue_mul_b", 32'(mul_b[d]), 32'(eb));
      check("issue_ready", 32'({req0_ready[d], req1_ready[d]}), 32'd0);
    end
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid[d]), 32'd1);
    check("rsp_product", 32'(rsp_product[d]), 32'(ep));
    check("rsp_id", 32'(rsp_id[d]), 32'(w));
    check("rsp_ready_out", 32'({req0_ready[d], req1_ready[d]}), 32'd0);
    rsp_ready[d] = (bp == 0);
    for (int j = 1; j <= bp; j++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[d]), 32'd1);
      check("hold_product", 32'(rsp_product[d]), 32'(ep));
      check("hold_id", 32'(rsp_id[d]), 32'(w));
      check("hold_ready", 32'({req0_ready[d], req1_ready[d]}), 32'd0);
      rsp_ready[d] = (j == bp);
    end
    @(negedge clk);
    count_m[d] = (count_m[d] + 1) & 32'hFFFF;
    check("done_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check("done_busy", 32'(busy[d]), 32'd0);
    check("done_op_count", 32'(op_count[d]), 32'(count_m[d]));
    check("done_mul_a_kept", 32'(mul_a[d]), 32'(ea));
    rsp_ready[d] = 1'b0;
    req0_valid[d] = 1'b0;
    req1_valid[d] = 1'b0;
  endtask

  task automatic check_reset(input int d);
    check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check("rst_busy", 32'(busy[d]), 32'd0);
    check("rst_op_count", 32'(op_count[d]), 32'd0);
    check("rst_mul_a", 32'(mul_a[d]), 32'd0);
    check("rst_mul_b", 32'(mul_b[d]), 32'd0);
    check("rst_rsp_product", 32'(rsp_product[d]), 32'd0);
    check("rst_rsp_id", 32'(rsp_id[d]), 32'd0);
  endtask

  initial begin
    rst_n = 2'b00;
    req0_valid = '0; req1_valid = '0; rsp_ready = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    last_m = '{1'b1, 1'b1};
    count_m = '{0, 0};
    repeat (2) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 2'b11;
    repeat (2) begin
      @(negedge clk);
      check("idle_busy", 32'(busy[0]), 32'd0);
      check("idle_ready", 32'({req0_ready[0], req1_ready[0]}), 32'd0);
    end

    // single op, max/zero/edge operands
    do_op(0, 1'b1, 4'd3, 4'd5, 1'b0, 4'd0, 4'd0, 0);
    do_op(0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 4'd15, 0);
    do_op(0, 1'b1, 4'd0, 4'd9, 1'b0, 4'd0, 4'd0, 0);
    do_op(0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 4'd15, 0);
    // contention after reset-like pointer: alternate strictly
    do_op(0, 1'b1, 4'd9, 4'd7, 1'b1, 4'd4, 4'd4, 0);
    do_op(0, 1'b1, 4'd9, 4'd7, 1'b1, 4'd4, 4'd4, 0);
    do_op(0, 1'b1, 4'd9, 4'd7, 1'b1, 4'd4, 4'd4, 0);
    // backpressure with the loser still requesting
    do_op(0, 1'b1, 4'd5, 4'd6, 1'b1, 4'd2, 4'd3, 5);

    // reset in the middle of ISSUE on the SETTLE=4 instance
    req0_valid[1] = 1'b1; req0_a[1] = 4'd2; req0_b[1] = 4'd3;
    @(posedge clk);
    #1 req0_valid[1] = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy[1]), 32'd1);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check_reset(1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    last_m[1] = 1'b1;
    do_op(1, 1'b1, 4'd11, 4'd2, 1'b1, 4'd3, 4'd3, 0);
    do_op(1, 1'b1, 4'd6, 4'd7, 1'b0, 4'd0, 4'd0, 0);

    for (int i = 0; i < 40; i++) begin
      int vv;
      vv = $urandom_range(1, 3);
      do_op(0, vv[0], 4'($urandom), 4'($urandom), vv[1], 4'($urandom), 4'($urandom),
            $urandom_range(0, 3));
    end
    for (int i = 0; i < 10; i++) begin
      int vv;
      vv = $urandom_range(1, 3);
      do_op(1, vv[0], 4'($urandom), 4'($urandom), vv[1], 4'($urandom), 4'($urandom),
            $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one combinational 4x4 multiplier instance between two requesters, such as the calculator front-end and a test/sequencer port.
- Arbitrates round-robin between the two requesters.
- Registers the winning operands onto the shared multiplier inputs.
- Waits a programmable settle time, then captures the 8-bit product.
- Returns the product with a valid/ready response handshake tagged with the requester ID.

Parameters:
OPW, 4, operand width; product width is 2*OPW; must match the shared multiplier.
SETTLE, 1, cycles the operands are held on the multiplier before product capture; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
req0_valid  in  1  requester 0 has an operation
req0_a  in  OPW  requester 0 operand A
req0_b  in  OPW  requester 0 operand B
req0_ready  out  1  requester 0 accepted this cycle
req1_valid  in  1  requester 1 has an operation
req1_a  in  OPW  requester 1 operand A
req1_b  in  OPW  requester 1 operand B
req1_ready  out  1  requester 1 accepted this cycle
mul_a  out  OPW  to shared multiplier a input (registered)
mul_b  out  OPW  to shared multiplier b input (registered)
mul_product  in  2*OPW  from shared multiplier product output
rsp_valid  out  1  result available
rsp_product  out  2*OPW  captured product (registered)
rsp_id  out  1  requester that issued the result
rsp_ready  in  1  consumer accepts result
busy  out  1  state != IDLE
op_count  out  16  completed responses, modulo 2^16

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and registers clear immediately.
  - state=IDLE; mul_a, mul_b, rsp_product, rsp_id, op_count all 0.
  - rsp_valid=0, busy=0, req*_ready=0.
  - Round-robin pointer last=1, so req0 wins the first contention.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - reqN_ready is combinational, asserted only for the winner and only in IDLE.
  - Only one valid: that requester wins.
  - Both valid: the requester != last wins.
  - On handshake (valid & ready) in cycle T:
    - latch winner's a/b into mul_a/mul_b, winner into rsp_id, last<=winner.
    - load settle counter with SETTLE-1; go ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - mul_a/mul_b held constant.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: rsp_product<=mul_product, rsp_valid<=1, go RESP.
- Latency: rsp_valid first high in cycle T+1+SETTLE. With SETTLE=1, accept in cycle 0 gives rsp_valid in cycle 2.
- RESP:
  - rsp_valid, rsp_product and rsp_id held stable until rsp_ready is sampled high.
  - On rsp_valid & rsp_ready: rsp_valid<=0, op_count<=op_count+1 (0xFFFF wraps to 0x0000), go IDLE.
  - rsp_ready high on the first RESP cycle completes in one cycle.
- Throughput: at most one operation per SETTLE+2 cycles. There is no accept in the same cycle as a response completes; the next accept is in the following IDLE cycle.
- Requests arriving in ISSUE or RESP are not accepted (ready=0). Requesters must hold valid and operands stable until ready.
- A requester dropping valid before acceptance has no effect.
- Width rule: product is unsigned 2*OPW bits straight from mul_product; no truncation or overflow flag.
- mul_a/mul_b retain the last operands while IDLE; they do not return to 0.
- Reset mid-operation (ISSUE or RESP): the pending result is discarded with no response, and the counter is not incremented.
- SETTLE outside 1..15 is unsupported. A simulation check flags it at elaboration.

Test Plan:
1. Single op, SETTLE=1: req0 3x5 in cycle 0 -> req0_ready=1 in cycle 0; mul_a=3, mul_b=5 from cycle 1; rsp_valid=1 in cycle 2 with product 15, id 0; rsp_ready=1 -> op_count=1.
2. Max operands: req1 15x15 -> rsp_product=225 (0xE1), rsp_id=1; also 0x9=0 and 1x15=15.
3. Contention: both valid from cycle 0 (req0 9x7, req1 4x4), rsp_ready tied 1 -> responses in order: 63 id0, then 16 id1; third contention grants req0 again (strict alternation).
4. Backpressure: rsp_ready low 5 cycles after rsp_valid -> rsp_valid, product and id stay constant; req0_ready and req1_ready stay 0 throughout; completes on first rsp_ready high.
5. SETTLE=4: req0 6x7 accepted cycle 0 -> mul_a/mul_b stable cycles 1-4; rsp_valid at cycle 5 with 42.
6. Reset during ISSUE: assert rst_n=0 mid-ISSUE -> rsp_valid=0, busy=0, op_count unchanged at 0; after release a simultaneous req0/req1 grants req0 first.
